baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
Runtime-selectable UART baud-rate tick generator and the successor to the fixed single-rate tick counter. It produces an oversampled tick (`os_tick`) for RX mid-bit sampling and a bit-rate tick (`bit_tick`) for TX. A fractional error accumulator makes the average tick rate exact for any `CLK_HZ`/baud pair. It sits between the UART core clock domain and the uart_tx/uart_rx FSMs and supports phase realignment on RX start-bit detection.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, `os_tick` periods per bit; must be ≥ 2 and a power of 2.
- SIM_DIV, 0, if nonzero, every os period is exactly SIM_DIV cycles (remainder forced to 0, `baud_sel` ignored for period length); used for fast simulation.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  generator enable; low holds all counters at zero.
- baud_sel  in  3  rate index: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
- restart  in  1  synchronous phase realign pulse, e.g. from RX start-bit edge.
- os_tick  out  1  one-cycle pulse at BAUD×OVERSAMPLE average rate.
- bit_tick  out  1  one-cycle pulse, coincident with every OVERSAMPLE-th `os_tick`.
- os_phase  out  clog2(OVERSAMPLE)  index of the current os period within the bit, 0..OVERSAMPLE-1.

Behaviour:
- Per-rate constants, evaluated at elaboration:
  - DEN = BAUD×OVERSAMPLE
  - DIV_INT = CLK_HZ / DEN (integer division)
  - DIV_REM = CLK_HZ mod DEN
  - Elaboration-time assertion: DIV_INT ≥ 2 for all 8 rates.
- Registers:
  - `cnt` (cycle counter, width clog2(max DIV_INT+1))
  - `len_ext` (1 bit; current period is DIV_INT+1)
  - `err` (width clog2(max DEN))
  - `os_cnt`
  - `sel_q` (registered `baud_sel`)
  - `os_tick`, `bit_tick` (both registered outputs)
- Reset: `cnt`=0, `err`=0, `len_ext`=0, `os_cnt`=0, `sel_q`=0, `os_tick`=0, `bit_tick`=0, `os_phase`=0.
- Clear priority, highest first; each clear is synchronous and affects that edge only:
  - `en`=0: `cnt`, `err`, `len_ext`, `os_cnt` ← 0; ticks ← 0.
  - `baud_sel`≠`sel_q`: `sel_q` ← `baud_sel`; `cnt`, `err`, `len_ext`, `os_cnt` ← 0; ticks ← 0 for that cycle.
  - `restart`=1: `cnt`, `err`, `len_ext`, `os_cnt` ← 0; ticks ← 0. A `restart` coincident with a terminal count suppresses that tick.
- Normal operation:
  - Period length is P = DIV_INT + `len_ext`.
  - While `cnt` < P-1: `cnt`++; ticks ← 0.
  - When `cnt` = P-1:
    - `cnt` ← 0 and `os_tick` ← 1.
    - err_sum = `err` + DIV_REM. If err_sum ≥ DEN: `err` ← err_sum − DEN and `len_ext` ← 1. Otherwise `err` ← err_sum and `len_ext` ← 0.
    - `bit_tick` ← 1 iff `os_cnt` = OVERSAMPLE-1.
    - `os_cnt` wraps to 0 modulo OVERSAMPLE.
- Latency: with `en` high and no clears, the first `os_tick` is high in the cycle following the DIV_INT-th rising edge after the last clear. The first `bit_tick` arrives on the OVERSAMPLE-th `os_tick`.
- `os_phase` = `os_cnt`. It is valid while `en`=1, and equals OVERSAMPLE/2 during the mid-bit os period.
- Averaging guarantee: over DEN/gcd(CLK_HZ mod DEN, DEN) os periods, the cycle count is exact. Each individual os period is DIV_INT or DIV_INT+1 cycles.
- `err` never reaches DEN (invariant, asserted in simulation).
- `os_tick` and `bit_tick` are never high for two consecutive cycles.

Decomposition:
- Package `uart_pkg`:
  - BAUD_TABLE[0:7] constant array.
  - Functions `div_int(clk_hz, baud, os)` and `div_rem(clk_hz, baud, os)`.
  - Localparam `BAUD_SEL_W`=3.
  - Shared with uart_tx/uart_rx.
- Sub-module `frac_period_ctr`:
  - Inputs: DIV_INT, DIV_REM, DEN as runtime operands, plus clear.
  - Output: `period_done` pulse.
  - Owns `cnt`, `err`, `len_ext`.
- Top level owns: `sel_q`, rate-table mux, `os_cnt`, `bit_tick`, priority clear logic.

Test Plan:
- `baud_sel`=0, `en`=1, CLK_HZ=100e6, OVERSAMPLE=16 -> os periods are 651 cycles, with exactly one 652-cycle period per 24; 24 consecutive os periods total 15625 cycles; `bit_tick` spacing is 10416/10417 and sums to exactly 1_000_000 cycles over 96 bits.
- SIM_DIV=20, `en` high after reset release -> first `os_tick` after 20 edges, then every 20 cycles; `bit_tick` every 320 cycles; `os_phase` cycles 0..15.
- `baud_sel` switched 0→4 mid-period -> no tick in the switch cycle; next `os_tick` 54 cycles later; over 4 os periods, one period is 55 cycles (DIV_REM=467200, DEN=1843200).
- `restart` pulsed at `cnt`=300, `os_cnt`=7 -> `os_phase`=0 next cycle; next `os_tick` 651 cycles after the restart edge; `restart` on a terminal count -> that tick suppressed.
- `en` dropped for 5 cycles then raised -> ticks 0 while low; `os_phase`=0; first `os_tick` DIV_INT edges after `en` is sampled high.
- reset asserted asynchronously mid-period with `os_tick` high -> all outputs 0 immediately (same cycle, no clock edge); `sel_q`=0 after release; 921600 (`baud_sel`=7) -> periods of 6/7 cycles, never consecutive ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: baud rate table and divider helpers shared by the UART blocks
package uart_pkg;
  localparam int BAUD_SEL_W = 3;
  localparam int BAUD_TABLE [0:7] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
  function automatic int div_int(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
  function automatic int div_rem(input int clk_hz, input int baud, input int os);
    return clk_hz % (baud * os);
  endfunction
endpackage

// File: rtl/frac_period_ctr.sv
// frac_period_ctr: DIV_INT or DIV_INT+1 cycle periods whose average is DEN-exact
module frac_period_ctr #(
  parameter int CW = 10,
  parameter int EW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [CW-1:0] div_int,
  input  logic [EW-1:0] div_rem,
  input  logic [EW:0]   den,
  output logic          period_done
);
  logic [CW-1:0] cnt;
  logic [EW-1:0] err;
  logic          len_ext;
  logic [EW:0]   sum;
  logic          last;
  logic          wrap;
  always_comb begin
    last        = cnt == div_int - CW'(!len_ext);
    sum         = {1'b0, err} + {1'b0, div_rem};
    wrap        = sum >= den;
    period_done = !clear && last;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      err     <= '0;
      len_ext <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      err     <= '0;
      len_ext <= 1'b0;
    end else if (last) begin
      cnt     <= '0;
      err     <= wrap ? EW'(sum - den) : sum[EW-1:0];
      len_ext <= wrap;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
  a_err_lt_den: assert property (@(posedge clk) disable iff (reset) {1'b0, err} < den);
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: selectable-rate oversample and bit tick generator with phase realign
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int SIM_DIV    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [BAUD_SEL_W-1:0]         baud_sel,
  input  logic                          restart,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
  localparam int PW     = $clog2(OVERSAMPLE);
  localparam int MAXDIV = SIM_DIV != 0 ? SIM_DIV : div_int(CLK_HZ, BAUD_TABLE[0], OVERSAMPLE);
  localparam int CW     = $clog2(MAXDIV + 1);
  localparam int EW     = $clog2(BAUD_TABLE[7] * OVERSAMPLE);
  logic [CW-1:0]         div_tab [8];
  logic [EW-1:0]         rem_tab [8];
  logic [EW:0]           den_tab [8];
  logic [BAUD_SEL_W-1:0] sel_q;
  logic [PW-1:0]         os_cnt;
  logic                  clear;
  logic                  done;
  if (OVERSAMPLE < 2 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be a power of 2 and at least 2");
  end
  for (genvar i = 0; i < 8; i++) begin : g_rate
    localparam int DEN = BAUD_TABLE[i] * OVERSAMPLE;
    localparam int DI  = SIM_DIV != 0 ? SIM_DIV : div_int(CLK_HZ, BAUD_TABLE[i], OVERSAMPLE);
    localparam int DR  = SIM_DIV != 0 ? 0 : div_rem(CLK_HZ, BAUD_TABLE[i], OVERSAMPLE);
    if (DI < 2) begin : g_bad_div
      $error("clock too slow for baud rate index %0d", i);
    end
    assign div_tab[i] = CW'(DI);
    assign rem_tab[i] = EW'(DR);
    assign den_tab[i] = (EW + 1)'(DEN);
  end
  assign clear    = !en || baud_sel != sel_q || restart;
  assign os_phase = os_cnt;
  frac_period_ctr #(.CW(CW), .EW(EW)) u_ctr (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .div_int     (div_tab[sel_q]),
    .div_rem     (rem_tab[sel_q]),
    .den         (den_tab[sel_q]),
    .period_done (done)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= done;
      bit_tick <= done && &os_cnt;
      if (clear) os_cnt <= '0;
      else if (done) os_cnt <= os_cnt + PW'(1);
      if (en) sel_q <= baud_sel;
    end
  end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed checks of both the real-rate and SIM_DIV=20 generators
module tb_baud_tick_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] baud_sel = 3'd0;
  logic       a_os, a_bit, b_os, b_bit;
  logic [3:0] a_ph, b_ph;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  baud_tick_gen u_a (
    .clk(clk), .reset(reset), .en(en), .baud_sel(baud_sel), .restart(restart),
    .os_tick(a_os), .bit_tick(a_bit), .os_phase(a_ph)
  );
  baud_tick_gen #(.SIM_DIV(20)) u_b (
    .clk(clk), .reset(reset), .en(en), .baud_sel(baud_sel), .restart(restart),
    .os_tick(b_os), .bit_tick(b_bit), .os_phase(b_ph)
  );
  function automatic logic sig(input int w);
    return w == 0 ? a_os : w == 1 ? a_bit : w == 2 ? b_os : b_bit;
  endfunction
  task automatic wait_tick(input int w, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (sig(w)) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; en = 1'b1; baud_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_os !== 1'b0) begin errors++; $display("FAIL reset_os got %b exp 0", a_os); end
    checks++; if (a_bit !== 1'b0) begin errors++; $display("FAIL reset_bit got %b exp 0", a_bit); end
    checks++; if (a_ph !== 4'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", a_ph); end
    checks++; if (b_os !== 1'b0) begin errors++; $display("FAIL reset_b_os got %b exp 0", b_os); end
    checks++; if (u_a.sel_q !== 3'd0) begin errors++; $display("FAIL reset_sel_q got %0d exp 0", u_a.sel_q); end
  endtask
  task automatic test_sim_div();
    int n;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      wait_tick(2, 40, n);
      checks++; if (n !== 20) begin errors++; $display("FAIL sim_period k=%0d got %0d exp 20", k, n); end
      checks++; if (b_ph !== 4'((k + 1) % 16)) begin errors++; $display("FAIL sim_phase k=%0d got %0d exp %0d", k, b_ph, (k + 1) % 16); end
      checks++; if (b_bit !== (k == 15)) begin errors++; $display("FAIL sim_bit k=%0d got %b exp %b", k, b_bit, k == 15); end
    end
    wait_tick(3, 400, n);
    checks++; if (n !== 320) begin errors++; $display("FAIL sim_bit_period got %0d exp 320", n); end
  endtask
  task automatic test_frac();
    int p [1:48];
    int tot, longs, win;
    do_reset();
    tot = 0; longs = 0; win = 0;
    for (int i = 1; i <= 48; i++) begin
      wait_tick(0, 700, p[i]);
      tot += p[i];
      if (p[i] == 652) longs++;
      if (i >= 2 && i <= 25) win += p[i];
      checks++; if (p[i] != 651 && p[i] != 652) begin errors++; $display("FAIL frac_period i=%0d got %0d exp 651/652", i, p[i]); end
      if (i == 16 || i == 32) begin
        checks++; if (a_bit !== 1'b1) begin errors++; $display("FAIL frac_bit i=%0d got %b exp 1", i, a_bit); end
        checks++; if (tot !== (i == 16 ? 10416 : 20833)) begin errors++; $display("FAIL frac_bit_time i=%0d got %0d exp %0d", i, tot, i == 16 ? 10416 : 20833); end
      end
    end
    checks++; if (p[25] !== 652) begin errors++; $display("FAIL frac_long_pos got %0d exp 652", p[25]); end
    checks++; if (longs !== 1) begin errors++; $display("FAIL frac_long_count got %0d exp 1", longs); end
    checks++; if (win !== 15625) begin errors++; $display("FAIL frac_window got %0d exp 15625", win); end
  endtask
  task automatic test_sel_switch();
    int n;
    int exp_p [5] = '{54, 54, 54, 54, 55};
    wait_tick(0, 700, n);
    repeat (100) @(posedge clk);
    #1;
    baud_sel = 3'd4;
    @(posedge clk); #1;
    checks++; if (a_os !== 1'b0) begin errors++; $display("FAIL switch_tick got %b exp 0", a_os); end
    checks++; if (a_ph !== 4'd0) begin errors++; $display("FAIL switch_phase got %0d exp 0", a_ph); end
    for (int i = 0; i < 5; i++) begin
      wait_tick(0, 100, n);
      checks++; if (n !== exp_p[i]) begin errors++; $display("FAIL switch_period i=%0d got %0d exp %0d", i, n, exp_p[i]); end
    end
  endtask
  task automatic test_restart();
    int n;
    baud_sel = 3'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) wait_tick(0, 700, n);
    checks++; if (a_ph !== 4'd7) begin errors++; $display("FAIL restart_pre_phase got %0d exp 7", a_ph); end
    repeat (300) @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checks++; if (a_ph !== 4'd0) begin errors++; $display("FAIL restart_phase got %0d exp 0", a_ph); end
    wait_tick(0, 700, n);
    checks++; if (n !== 651) begin errors++; $display("FAIL restart_period got %0d exp 651", n); end
    repeat (650) @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    checks++; if (a_os !== 1'b0) begin errors++; $display("FAIL restart_suppress got %b exp 0", a_os); end
    wait_tick(0, 700, n);
    checks++; if (n !== 651) begin errors++; $display("FAIL restart_after_suppress got %0d exp 651", n); end
  endtask
  task automatic test_enable();
    int n;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (a_os !== 1'b0) begin errors++; $display("FAIL en_low_os i=%0d got %b exp 0", i, a_os); end
      checks++; if (a_bit !== 1'b0) begin errors++; $display("FAIL en_low_bit i=%0d got %b exp 0", i, a_bit); end
      checks++; if (a_ph !== 4'd0) begin errors++; $display("FAIL en_low_phase i=%0d got %0d exp 0", i, a_ph); end
    end
    en = 1'b1;
    wait_tick(0, 700, n);
    checks++; if (n !== 651) begin errors++; $display("FAIL en_first_tick got %0d exp 651", n); end
  endtask
  task automatic test_async_reset();
    int n;
    wait_tick(0, 700, n);
    checks++; if (a_os !== 1'b1) begin errors++; $display("FAIL areset_pre_os got %b exp 1", a_os); end
    #1 reset = 1'b1;
    #1;
    checks++; if (a_os !== 1'b0) begin errors++; $display("FAIL areset_os got %b exp 0", a_os); end
    checks++; if (a_bit !== 1'b0) begin errors++; $display("FAIL areset_bit got %b exp 0", a_bit); end
    checks++; if (a_ph !== 4'd0) begin errors++; $display("FAIL areset_phase got %0d exp 0", a_ph); end
  endtask
  task automatic test_fast();
    int n, gap;
    logic prev;
    int exp_p [7] = '{6, 6, 7, 7, 7, 6, 7};
    baud_sel = 3'd7;
    checks++; if (u_a.sel_q !== 3'd0) begin errors++; $display("FAIL fast_sel_q_reset got %0d exp 0", u_a.sel_q); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_os !== 1'b0) begin errors++; $display("FAIL fast_switch_tick got %b exp 0", a_os); end
    for (int i = 0; i < 7; i++) begin
      wait_tick(0, 20, n);
      checks++; if (n !== exp_p[i]) begin errors++; $display("FAIL fast_period i=%0d got %0d exp %0d", i, n, exp_p[i]); end
    end
    gap = 0; prev = a_os;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      gap++;
      checks++; if ((a_os && prev) !== 1'b0) begin errors++; $display("FAIL fast_consecutive i=%0d got 1 exp 0", i); end
      if (a_os) begin
        checks++; if (gap != 6 && gap != 7) begin errors++; $display("FAIL fast_gap i=%0d got %0d exp 6/7", i, gap); end
        gap = 0;
      end
      prev = a_os;
    end
  endtask
  initial begin
    test_reset();
    test_sim_div();
    test_frac();
    test_sel_switch();
    test_restart();
    test_enable();
    test_async_reset();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
